// File: rtl/store_pkg.sv
// store_pkg: store size encoding, byte-mask helper and widest supported bus width.
package store_pkg;
   localparam int MAX_DATA_W = 64;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} store_size_e;
   function automatic logic [MAX_DATA_W/8-1:0] size_mask(store_size_e sz);
      return sz == SZ_D ? 8'hFF : sz == SZ_W ? 8'h0F : sz == SZ_H ? 8'h03 : 8'h01;
   endfunction
endpackage

// File: rtl/lane_placer.sv
// lane_placer: places store bytes on bus lanes; the upper half of the double-width shift is the spill-over beat.
module lane_placer
   import store_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]           wd_i,
   input  logic [$clog2(DATA_W/8)-1:0] ofs_i,
   input  store_size_e                 size_i,
   output logic [DATA_W-1:0]           d0_o,
   output logic [DATA_W-1:0]           d1_o,
   output logic [DATA_W/8-1:0]         s0_o,
   output logic [DATA_W/8-1:0]         s1_o,
   output logic                        split_o
);
   localparam int NB = DATA_W / 8;
   logic [NB-1:0]       m;
   logic [DATA_W-1:0]   wd_m;
   logic [2*DATA_W-1:0] dw;
   logic [2*NB-1:0]     sw;
   always_comb begin
      m = NB'(size_mask(size_i));
      wd_m = '0;
      for (int i = 0; i < NB; i++) wd_m[8*i+:8] = m[i] ? wd_i[8*i+:8] : 8'h00;
      dw = {{DATA_W{1'b0}}, wd_m} << {ofs_i, 3'b000};
      sw = {{NB{1'b0}}, m} << ofs_i;
   end
   assign d0_o    = dw[DATA_W-1:0];
   assign d1_o    = dw[2*DATA_W-1:DATA_W];
   assign s0_o    = sw[NB-1:0];
   assign s1_o    = sw[2*NB-1:NB];
   assign split_o = |sw[2*NB-1:NB];
endmodule

// File: rtl/store_aligner.sv
// store_aligner: registered store alignment to DATA_W bus beats, splitting boundary-crossing stores in two.
// STORE_ALIGNER_MISALIGN_TRAP_EN: crossing stores raise a one-cycle misalign_err instead of issuing beats.
module store_aligner
   import store_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [1:0]          req_size,
   input  logic [DATA_W-1:0]   req_wd,
   output logic                bus_valid,
   input  logic                bus_ready,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_wstrb,
   output logic                busy
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
   ,
   output logic                misalign_err
`endif
);
   localparam int NB = DATA_W / 8;
   localparam int OW = $clog2(NB);
   typedef enum logic [1:0] {IDLE, LAST, FIRST} state_e;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, d0, d1;
   logic [NB-1:0]     wstrb_q, wstrb_d, s0, s1;
   logic              split, accept;
   store_size_e       sz;
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
   logic              err_q, err_d;
`else
   logic [DATA_W-1:0] d1_q, d1_d;
   logic [NB-1:0]     s1_q, s1_d;
`endif
   // a dword on a 32-bit bus is illegal; degrade it to a word
   assign sz = (DATA_W == 32 && req_size == 2'd3) ? SZ_W : store_size_e'(req_size);
   lane_placer #(.DATA_W(DATA_W)) u_place (
      .wd_i(req_wd), .ofs_i(req_addr[OW-1:0]), .size_i(sz),
      .d0_o(d0), .d1_o(d1), .s0_o(s0), .s1_o(s1), .split_o(split)
   );
   assign req_ready = state_q == IDLE || (state_q == LAST && bus_ready);
   assign accept    = req_valid && req_ready;
   assign bus_valid = state_q != IDLE;
   assign busy      = state_q != IDLE;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_wstrb = wstrb_q;
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
   assign misalign_err = err_q;
`endif
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
      err_d = 1'b0;
`else
      d1_d = d1_q;
      s1_d = s1_q;
`endif
      if (state_q == FIRST && bus_ready) begin
         state_d = LAST;
         addr_d  = addr_q + ADDR_W'(NB);
`ifndef STORE_ALIGNER_MISALIGN_TRAP_EN
         wdata_d = d1_q;
         wstrb_d = s1_q;
`endif
      end else if (state_q == LAST && bus_ready) state_d = IDLE;
      if (accept) begin
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
         err_d   = split;
         state_d = split ? IDLE : LAST;
         if (!split) begin
            addr_d  = req_addr & ~ADDR_W'(NB - 1);
            wdata_d = d0;
            wstrb_d = s0;
         end
`else
         state_d = split ? FIRST : LAST;
         addr_d  = req_addr & ~ADDR_W'(NB - 1);
         wdata_d = d0;
         wstrb_d = s0;
         d1_d    = d1;
         s1_d    = s1;
`endif
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
         err_q   <= 1'b0;
`else
         d1_q    <= '0;
         s1_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
         err_q   <= err_d;
`else
         d1_q    <= d1_d;
         s1_q    <= s1_d;
`endif
      end
   end
   a_no_dword_on_32: assert property (@(posedge clk) disable iff (reset)
      !(req_valid && DATA_W == 32 && req_size == 2'd3));
endmodule

// File: tb/tb_store_aligner.sv
// tb_store_aligner: directed table, hand-written corner sequences and a randomized scoreboard run (DATA_W=32).
module tb_store_aligner;
   logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, bus_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wd = '0;
   logic [1:0]  req_size = '0;
   logic        req_ready, bus_valid, busy;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
   logic        misalign_err;
`endif
   int n_cmp = 0, n_bad = 0;

   store_aligner #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_size(req_size), .req_wd(req_wd),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .busy(busy)
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
      , .misalign_err(misalign_err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "timeout");
   end

   typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} beat_t;
   typedef struct {logic [31:0] addr; logic [1:0] size; logic [31:0] wd; logic [31:0] ea; logic [31:0] ed; logic [3:0] es;} vec_t;
   beat_t exp_q[$];
   beat_t held;
   logic  hold = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference: write the store byte by byte into memory, grouping bytes by aligned word
   task automatic model_push(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      beat_t       b[2];
      int          nb, lane;
      logic [31:0] ab, ba;
      nb = 0;
      for (int i = 0; i < (1 << sz); i++) begin
         ab   = a + 32'(i);
         ba   = {ab[31:2], 2'b00};
         lane = int'(ab[1:0]);
         if (nb == 0 || b[nb-1].addr != ba) begin
            b[nb] = '{ba, 32'h0, 4'h0};
            nb++;
         end
         b[nb-1].data[8*lane+:8] = wd[8*i+:8];
         b[nb-1].strb[lane]      = 1'b1;
      end
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
      if (nb == 2) return;
`endif
      for (int k = 0; k < nb; k++) exp_q.push_back(b[k]);
   endtask

   task automatic sample_bus();
      beat_t e;
      if (hold) begin
         chk("hold_valid", bus_valid, 1);
         chk("hold_addr", bus_addr, held.addr);
         chk("hold_data", bus_wdata, held.data);
         chk("hold_strb", bus_wstrb, held.strb);
      end
      hold = 1'b0;
      if (bus_valid && bus_ready) begin
         if (exp_q.size() == 0) chk("rnd_unexpected_beat", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("rnd_addr", bus_addr, e.addr);
            chk("rnd_data", bus_wdata, e.data);
            chk("rnd_strb", bus_wstrb, e.strb);
         end
      end else if (bus_valid) begin
         held = '{bus_addr, bus_wdata, bus_wstrb};
         hold = 1'b1;
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      req_valid = 1'b1;
      req_addr  = a;
      req_size  = sz;
      req_wd    = wd;
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{32'h1003, 2'd0, 32'h000000AB, 32'h1000, 32'hAB000000, 4'b1000};
      tbl[1] = '{32'h1002, 2'd1, 32'hFFFF1234, 32'h1000, 32'h12340000, 4'b1100};
      tbl[2] = '{32'h2000, 2'd2, 32'hDEADBEEF, 32'h2000, 32'hDEADBEEF, 4'b1111};
      tbl[3] = '{32'h2005, 2'd0, 32'h12345678, 32'h2004, 32'h00007800, 4'b0010};
      tbl[4] = '{32'h3006, 2'd1, 32'h89ABCDEF, 32'h3004, 32'hCDEF0000, 4'b1100};
      tbl[5] = '{32'h3000, 2'd1, 32'hABCD5678, 32'h3000, 32'h00005678, 4'b0011};
      tbl[6] = '{32'h3001, 2'd1, 32'h1111BEEF, 32'h3000, 32'h00BEEF00, 4'b0110};

      repeat (2) tick();
      chk("in_reset_valid", bus_valid, 0);
      reset = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_data", bus_wdata, 0);
      chk("rst_strb", bus_wstrb, 0);
      tick();

      for (int v = 0; v < 7; v++) begin
         drive(tbl[v].addr, tbl[v].size, tbl[v].wd);
         bus_ready = 1'b0;
         #1;
         chk("tbl_req_ready", req_ready, 1);
         tick();
         req_valid = 1'b0;
         chk("tbl_valid", bus_valid, 1);
         chk("tbl_addr", bus_addr, tbl[v].ea);
         chk("tbl_data", bus_wdata, tbl[v].ed);
         chk("tbl_strb", bus_wstrb, tbl[v].es);
         bus_ready = 1'b1;
         tick();
         chk("tbl_busy_drop", busy, 0);
         bus_ready = 1'b0;
      end

`ifndef STORE_ALIGNER_MISALIGN_TRAP_EN
      drive(32'h1001, 2'd2, 32'hDDCCBBAA);
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("split_b0_valid", bus_valid, 1);
         chk("split_b0_addr", bus_addr, 32'h1000);
         chk("split_b0_data", bus_wdata, 32'hCCBBAA00);
         chk("split_b0_strb", bus_wstrb, 4'b1110);
         chk("split_b0_req_ready", req_ready, 0);
         tick();
      end
      bus_ready = 1'b1;
      #1;
      chk("split_first_req_ready", req_ready, 0);
      tick();
      chk("split_b1_valid", bus_valid, 1);
      chk("split_b1_addr", bus_addr, 32'h1004);
      chk("split_b1_data", bus_wdata, 32'h000000DD);
      chk("split_b1_strb", bus_wstrb, 4'b0001);
      chk("split_b1_req_ready", req_ready, 1);
      tick();
      chk("split_busy_drop", busy, 0);

      drive(32'hFFFFFFFE, 2'd2, 32'h44332211);
      tick();
      req_valid = 1'b0;
      chk("wrap_b0_addr", bus_addr, 32'hFFFFFFFC);
      chk("wrap_b0_data", bus_wdata, 32'h22110000);
      chk("wrap_b0_strb", bus_wstrb, 4'b1100);
      tick();
      chk("wrap_b1_addr", bus_addr, 32'h00000000);
      chk("wrap_b1_data", bus_wdata, 32'h00004433);
      chk("wrap_b1_strb", bus_wstrb, 4'b0011);
      tick();
      chk("wrap_busy_drop", busy, 0);
`endif

      bus_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(32'(4 * k), 2'd2, 32'hA0A0A000 + 32'(k));
         #1;
         chk("b2b_req_ready", req_ready, 1);
         tick();
         chk("b2b_valid", bus_valid, 1);
         chk("b2b_addr", bus_addr, 32'(4 * k));
         chk("b2b_data", bus_wdata, 32'hA0A0A000 + 32'(k));
      end
      req_valid = 1'b0;
      tick();
      chk("b2b_busy_drop", busy, 0);

      bus_ready = 1'b0;
      drive(32'h1001, 2'd2, 32'hDDCCBBAA);
      tick();
      req_valid = 1'b0;
`ifdef STORE_ALIGNER_MISALIGN_TRAP_EN
      chk("trap_err_pulse", misalign_err, 1);
      chk("trap_no_valid", bus_valid, 0);
      tick();
      chk("trap_err_clear", misalign_err, 0);
      chk("trap_idle", busy, 0);
`else
      chk("rstmid_valid_before", bus_valid, 1);
      reset = 1'b1;
      #1;
      chk("rstmid_valid_async", bus_valid, 0);
      chk("rstmid_busy_async", busy, 0);
      tick();
      reset     = 1'b0;
      bus_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rstmid_no_beat1", bus_valid, 0);
      end
`endif

      for (int c = 0; c < 3000; c++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 7))) : $urandom;
         req_valid = 1'($urandom_range(0, 1));
         req_addr  = a;
         req_size  = 2'($urandom_range(0, 2));
         req_wd    = $urandom;
         bus_ready = $urandom_range(0, 3) != 0;
         #1;
         sample_bus();
         if (req_valid && req_ready) model_push(req_addr, req_size, req_wd);
         tick();
      end
      req_valid = 1'b0;
      bus_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         sample_bus();
         tick();
      end
      chk("rnd_drained", 32'(exp_q.size()), 0);
      chk("rnd_final_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
